spi_target_wide: RTL

- SPI target (peripheral) front end with a configurable word width, SPI mode (CPOL/CPHA) and bit order.
- Oversamples the asynchronous SPI pins in the `clk` domain. Delivers each received word with a one-cycle strobe and fetches the next transmit word with a one-cycle strobe.
- Sits between the external SPI pins and the host-side command decoder. Targets designs that need 16/32-bit transfers or non-mode-0 initiators.

---
 rtl/spi_target_wide.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_target_wide.sv
`timescale 1ns/1ps
// SPI target front end: oversampled pins, WORD_W-bit words, any CPOL/CPHA, MSB/LSB first. SPI_TARGET_ABORT_EN adds the partial-word abort pulse.
// Latency: internal action SYNC_STAGES+1 clk edges after a pin edge; receive strobe in that same cycle.
// Backpressure: none; the host must have transmit_word_i ready before each transmit strobe.
module spi_target_wide #(
   parameter int WORD_W      = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int LSB_FIRST   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              spi_sck_i,
   input  logic              spi_copi_i,
   output logic              spi_cipo_o,
   input  logic              spi_cs_i,
   output logic              receive_strobe_o,
   output logic [WORD_W-1:0] receive_word_o,
   output logic              transmit_strobe_o,
   input  logic [WORD_W-1:0] transmit_word_i,
   output logic              busy_o,
   output logic              abort_o
);

   localparam int               CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_W - 1);
   localparam logic             IDLE  = (CPOL != 0);

   logic [SYNC_STAGES-1:0] sck_sync, copi_sync, cs_sync;
   logic                   sck_q, cs_q;
   logic                   sck_s, copi_s, cs_s;
   logic                   lead_edge, trail_edge, sel_start, sel_end;
   logic [WORD_W-1:0]      shreg, shifted;
   logic [CNT_W-1:0]       cnt;
   logic                   half;

   function automatic logic out_bit(input logic [WORD_W-1:0] r);
      return (LSB_FIRST != 0) ? r[0] : r[WORD_W-1];
   endfunction

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign copi_s = copi_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];

   // History flops reset to 0 (CS "active"), so a frame open at reset needs a fresh select.
   always_comb begin
      lead_edge  = (sck_s != sck_q) && (sck_s != IDLE);
      trail_edge = (sck_s != sck_q) && (sck_s == IDLE);
      sel_start  = cs_q && !cs_s;
      sel_end    = !cs_q && cs_s && busy_o;
      if (LSB_FIRST != 0)
         shifted = {copi_s, shreg[WORD_W-1:1]};
      else
         shifted = {shreg[WORD_W-2:0], copi_s};
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         sck_sync          <= '0;
         copi_sync         <= '0;
         cs_sync           <= '0;
         sck_q             <= 1'b0;
         cs_q              <= 1'b0;
         receive_strobe_o  <= 1'b0;
         transmit_strobe_o <= 1'b0;
         receive_word_o    <= '0;
         shreg             <= '0;
         cnt               <= '0;
         half              <= 1'b0;
         busy_o            <= 1'b0;
         spi_cipo_o        <= 1'b0;
      end else begin
         sck_sync          <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
         copi_sync         <= {copi_sync[SYNC_STAGES-2:0], spi_copi_i};
         cs_sync           <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
         sck_q             <= sck_s;
         cs_q              <= cs_s;
         receive_strobe_o  <= 1'b0;
         transmit_strobe_o <= 1'b0;
         if (sel_start) begin
            busy_o            <= 1'b1;
            shreg             <= transmit_word_i;
            transmit_strobe_o <= 1'b1;
            cnt               <= '0;
            half              <= 1'b0;
            if (CPHA == 0) spi_cipo_o <= out_bit(transmit_word_i);
         end else if (sel_end) begin
            busy_o <= 1'b0;
            cnt    <= '0;
            half   <= 1'b0;
         end else if (busy_o) begin
            if (lead_edge && !half) begin
               half <= 1'b1;
               if (CPHA == 0) begin
                  shreg      <= shifted;
                  spi_cipo_o <= out_bit(shifted);
                  if (cnt == LAST) begin
                     receive_strobe_o <= 1'b1;
                     receive_word_o   <= shifted;
                  end
               end else begin
                  spi_cipo_o <= out_bit(shreg);
               end
            end else if (trail_edge && half) begin
               half <= 1'b0;
               if (cnt == LAST) begin
                  cnt               <= '0;
                  shreg             <= transmit_word_i;
                  transmit_strobe_o <= 1'b1;
                  if (CPHA == 0) begin
                     spi_cipo_o <= out_bit(transmit_word_i);
                  end else begin
                     receive_strobe_o <= 1'b1;
                     receive_word_o   <= shifted;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  if (CPHA != 0) shreg <= shifted;
               end
            end
         end
      end
   end

`ifdef SPI_TARGET_ABORT_EN
   always_ff @(posedge clk) begin
      if (reset_i)
         abort_o <= 1'b0;
      else
         abort_o <= sel_end && ((cnt != '0) || ((CPHA != 0) && half));
   end
`else
   assign abort_o = 1'b0;
`endif

endmodule
